// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: bundles the raw push-buttons and the counter-chain
// controls exchanged between the stopwatch controller and its surroundings.
//
// Signalling: there is no valid/ready handshake on this bundle. The button
// lines are raw, asynchronous, active-high levels owned by the master side.
// inc is a single-cycle strobe, cnt_rstn is an active-low strobe, and
// lap_hold, running and state are levels that are valid every cycle. All of
// these are owned by the slave side (the controller).
interface stopwatch_ctrl_if;
  logic       btn_start_stop;
  logic       btn_lap;
  logic       btn_clear;
  logic       inc;
  logic       cnt_rstn;
  logic       lap_hold;
  logic       running;
  logic [1:0] state;

  // Board or testbench side: drives the buttons and observes the controls.
  modport master (
    output btn_start_stop,
    output btn_lap,
    output btn_clear,
    input  inc,
    input  cnt_rstn,
    input  lap_hold,
    input  running,
    input  state
  );

  // Controller side.
  modport slave (
    input  btn_start_stop,
    input  btn_lap,
    input  btn_clear,
    output inc,
    output cnt_rstn,
    output lap_hold,
    output running,
    output state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear controller for the six-digit stopwatch
// counter chain. It conditions three raw buttons (synchronise, debounce,
// rising-edge pulse), sequences a four-state FSM, divides clk down to the
// 0.1 s increment strobe for digit 0, and drives the chain clear and the
// display freeze.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10_000_000, // clk cycles per increment, >= 2
  parameter int DEB_CNT  = 1_000_000   // stable cycles to accept a level, >= 1
) (
  input  logic            clk,
  input  logic            rstn,
  stopwatch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  // Button lane indices.
  localparam int NBTN    = 3;
  localparam int BTN_SS  = 0;
  localparam int BTN_LAP = 1;
  localparam int BTN_CLR = 2;

  // The debounce counter only ever has to hold 0..DEB_CNT-1, and the
  // prescaler 0..TICK_DIV-1.
  localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  // ---------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------
  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] sync_a;
  logic [NBTN-1:0] sync_b;
  logic [NBTN-1:0] stable;
  logic [NBTN-1:0] stable_d;
  logic [NBTN-1:0] press;
  logic [DW-1:0]   deb_cnt [NBTN];

  assign raw[BTN_SS]  = bus.btn_start_stop;
  assign raw[BTN_LAP] = bus.btn_lap;
  assign raw[BTN_CLR] = bus.btn_clear;

  // Two-flop synchroniser for the asynchronous button levels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Debounce: accept a new level only after DEB_CNT consecutive cycles of
  // disagreement with the current stable level; one agreeing cycle restarts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stable <= '0;
      for (int i = 0; i < NBTN; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (sync_b[i] != stable[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            stable[i]  <= sync_b[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Registered rising-edge detect: one-cycle press pulse, nothing on release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stable_d <= '0;
      press    <= '0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

  // Only one event is acted on per cycle: start_stop beats clear beats lap.
  logic ev_start_stop;
  logic ev_clear;
  logic ev_lap;

  assign ev_start_stop = press[BTN_SS];
  assign ev_clear      = press[BTN_CLR] & ~press[BTN_SS];
  assign ev_lap        = press[BTN_LAP] & ~press[BTN_SS] & ~press[BTN_CLR];

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   lap_hold_q;
  logic   lap_hold_d;
  logic   clear_d;
  logic   cnt_rstn_q;

  // State register plus the registered lap freeze and chain clear. Reset
  // holds the chain in clear; it is released on the first edge afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      lap_hold_q <= 1'b0;
      cnt_rstn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lap_hold_q <= lap_hold_d;
      cnt_rstn_q <= ~clear_d;
    end
  end

  // Next-state logic; events not listed for a state are ignored.
  always_comb begin
    state_d    = state_q;
    lap_hold_d = lap_hold_q;
    clear_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_start_stop) begin
          state_d = RUN;
        end else if (ev_clear) begin
          clear_d = 1'b1;
        end
      end
      RUN: begin
        if (ev_start_stop) begin
          state_d = PAUSE;
        end else if (ev_lap) begin
          state_d    = LAP;
          lap_hold_d = 1'b1;
        end
      end
      LAP: begin
        if (ev_start_stop) begin
          state_d    = PAUSE;
          lap_hold_d = 1'b0;
        end else if (ev_lap) begin
          state_d    = RUN;
          lap_hold_d = 1'b0;
        end
      end
      PAUSE: begin
        if (ev_start_stop) begin
          state_d = RUN;
        end else if (ev_clear) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        lap_hold_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Increment prescaler
  // ---------------------------------------------------------------------
  logic          counting;
  logic [PW-1:0] presc_q;
  logic          inc_q;

  assign counting = (state_q == RUN) || (state_q == LAP);

  // Count only while running. PAUSE keeps the partial tick so resuming does
  // not lose time; IDLE and a chain clear restart the count from zero. The
  // gate uses the current state, so a tick landing on the stop edge is still
  // issued and the resume edge itself never counts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= '0;
      inc_q   <= 1'b0;
    end else if (clear_d || (state_q == IDLE)) begin
      presc_q <= '0;
      inc_q   <= 1'b0;
    end else if (counting) begin
      if (presc_q == TICK_LAST) begin
        presc_q <= '0;
        inc_q   <= 1'b1;
      end else begin
        presc_q <= presc_q + PW'(1);
        inc_q   <= 1'b0;
      end
    end else begin
      inc_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.inc      = inc_q;
  assign bus.cnt_rstn = cnt_rstn_q;
  assign bus.lap_hold = lap_hold_q;
  assign bus.state    = state_q;
  assign bus.running  = counting;

endmodule
